mmu_walk_arbiter: RTL and testbench

Shares one read-only memory port between the instruction-side and data-side MMU page-table-walk requesters. It replaces the two independent per-MMU memory FSMs and their two AXI masters with one sequenced channel. Requester side uses the core-style level protocol: ren/address in, stall/rdata out. Memory side is a single-outstanding valid/ready read channel that feeds one CoreAxi_lite instance.

---
 rtl/mmu_walk_arbiter_pkg.sv | 19 +
 rtl/mmu_walk_arbiter_if.sv | 35 +++
 rtl/mmu_walk_arbiter_rr_arbiter2.sv | 35 +++
 rtl/mmu_walk_arbiter.sv | 112 +++++++++++
 tb/tb_mmu_walk_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmu_walk_arbiter_pkg.sv
// rtl/mmu_walk_arbiter_pkg.sv - shared types for the page-table-walk memory arbiter
package MMUArbStruct;

    localparam int ADDR_WIDTH_DEF = 64;
    localparam int DATA_WIDTH_DEF = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_IMMU = 1'b0;
    localparam req_id_t REQ_DMMU = 1'b1;

endpackage

// File: rtl/mmu_walk_arbiter_if.sv
// rtl/mmu_walk_arbiter_if.sv - requester and memory-side signals of the walk arbiter
interface mmu_walk_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  immu_ren;
    logic [ADDR_WIDTH-1:0] immu_address;
    logic [DATA_WIDTH-1:0] immu_rdata;
    logic                  immu_stall;
    logic                  dmmu_ren;
    logic [ADDR_WIDTH-1:0] dmmu_address;
    logic [DATA_WIDTH-1:0] dmmu_rdata;
    logic                  dmmu_stall;
    logic                  mem_ar_valid;
    logic                  mem_ar_ready;
    logic [ADDR_WIDTH-1:0] mem_araddr;
    logic                  mem_r_valid;
    logic                  mem_r_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Arbiter view: serves the two MMUs and masters the memory channel.
    modport slave (
        input  immu_ren, immu_address, dmmu_ren, dmmu_address,
        input  mem_ar_ready, mem_r_valid, mem_rdata,
        output immu_rdata, immu_stall, dmmu_rdata, dmmu_stall,
        output mem_ar_valid, mem_araddr, mem_r_ready
    );

    modport master (
        output immu_ren, immu_address, dmmu_ren, dmmu_address,
        output mem_ar_ready, mem_r_valid, mem_rdata,
        input  immu_rdata, immu_stall, dmmu_rdata, dmmu_stall,
        input  mem_ar_valid, mem_araddr, mem_r_ready
    );
endinterface

// File: rtl/mmu_walk_arbiter_rr_arbiter2.sv
// rtl/mmu_walk_arbiter_rr_arbiter2.sv - two-way round-robin pick with registered last grant
module rr_arbiter2
    import MMUArbStruct::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic       gnt_valid_o,
    output req_id_t    gnt_id_o
);
    req_id_t last_q;
    req_id_t last_d;

    always_comb begin
        gnt_valid_o = |req_i;
        if (req_i == 2'b11) begin
            gnt_id_o = req_id_t'(~last_q);
        end else if (req_i[1]) begin
            gnt_id_o = REQ_DMMU;
        end else begin
            gnt_id_o = REQ_IMMU;
        end
        last_d = en_i ? gnt_id_o : last_q;
    end

    // Reset to DMMU so the IMMU wins the first tie.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q <= REQ_DMMU;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/mmu_walk_arbiter.sv
// rtl/mmu_walk_arbiter.sv - sequences IMMU/DMMU walk reads onto one single-outstanding read port
module mmu_walk_arbiter
    import MMUArbStruct::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    mmu_walk_arbiter_if.slave  bus
);
    arb_state_t            state_q, state_d;
    req_id_t               owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] immu_rdata_q, immu_rdata_d;
    logic [DATA_WIDTH-1:0] dmmu_rdata_q, dmmu_rdata_d;
    logic                  immu_done_q, immu_done_d;
    logic                  dmmu_done_q, dmmu_done_d;

    logic [1:0] req;
    logic       gnt_en;
    logic       gnt_valid;
    req_id_t    gnt_id;
    logic       owner_ren;

    assign req       = {bus.dmmu_ren & ~dmmu_done_q, bus.immu_ren & ~immu_done_q};
    assign owner_ren = (owner_q == REQ_IMMU) ? bus.immu_ren : bus.dmmu_ren;

    rr_arbiter2 u_rr (
        .clk         (clk),
        .rstn        (rstn),
        .req_i       (req),
        .en_i        (gnt_en),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        immu_rdata_d = immu_rdata_q;
        dmmu_rdata_d = dmmu_rdata_q;
        immu_done_d  = 1'b0;
        dmmu_done_d  = 1'b0;
        gnt_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    gnt_en  = 1'b1;
                    owner_d = gnt_id;
                    addr_d  = (gnt_id == REQ_IMMU) ? bus.immu_address : bus.dmmu_address;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (bus.mem_ar_ready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                // An owner that dropped ren has aborted: drain the beat but keep old rdata.
                if (bus.mem_r_valid) begin
                    state_d = RESP;
                    if (owner_ren) begin
                        if (owner_q == REQ_IMMU) begin
                            immu_rdata_d = bus.mem_rdata;
                            immu_done_d  = 1'b1;
                        end else begin
                            dmmu_rdata_d = bus.mem_rdata;
                            dmmu_done_d  = 1'b1;
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            owner_q      <= REQ_IMMU;
            addr_q       <= '0;
            immu_rdata_q <= '0;
            dmmu_rdata_q <= '0;
            immu_done_q  <= 1'b0;
            dmmu_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            immu_rdata_q <= immu_rdata_d;
            dmmu_rdata_q <= dmmu_rdata_d;
            immu_done_q  <= immu_done_d;
            dmmu_done_q  <= dmmu_done_d;
        end
    end

    assign bus.mem_ar_valid = (state_q == ADDR);
    assign bus.mem_r_ready  = (state_q == DATA);
    assign bus.mem_araddr   = addr_q;
    assign bus.immu_rdata   = immu_rdata_q;
    assign bus.dmmu_rdata   = dmmu_rdata_q;
    assign bus.immu_stall   = bus.immu_ren & ~immu_done_q;
    assign bus.dmmu_stall   = bus.dmmu_ren & ~dmmu_done_q;
endmodule

// File: tb/tb_mmu_walk_arbiter.sv
// tb/tb_mmu_walk_arbiter.sv - scoreboard bench for mmu_walk_arbiter
module tb_mmu_walk_arbiter;
    import MMUArbStruct::*;

    localparam int AW = 64;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    mmu_walk_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mmu_walk_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            ar_delay = 0;
    int            r_delay  = 0;
    bit            inject_stray = 1'b0;
    logic [AW-1:0] last_ar_addr = '0;

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return {a[31:0], ~a[63:32]} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    // Memory responder: reacts at negedge, drives the next cycle's inputs.
    initial begin
        int            mphase;
        int            cnt;
        logic [AW-1:0] held;
        mphase = 0;
        cnt    = 0;
        held   = '0;
        bus.mem_ar_ready = 1'b0;
        bus.mem_r_valid  = 1'b0;
        bus.mem_rdata    = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                mphase = 0;
                cnt    = 0;
                bus.mem_ar_ready = 1'b0;
                bus.mem_r_valid  = 1'b0;
            end else begin
                case (mphase)
                    0: begin
                        if (inject_stray) begin
                            inject_stray    = 1'b0;
                            bus.mem_r_valid = 1'b1;
                            bus.mem_rdata   = 64'hDEAD_BEEF_DEAD_BEEF;
                            mphase          = 2;
                        end else if (bus.mem_ar_valid) begin
                            if (cnt == 0) begin
                                held = bus.mem_araddr;
                            end else begin
                                n_checks++;
                                if (bus.mem_araddr !== held) begin
                                    n_fail++;
                                    $display("FAIL araddr_stable got=%h required=%h", bus.mem_araddr, held);
                                end
                            end
                            if (cnt >= ar_delay) begin
                                bus.mem_ar_ready = 1'b1;
                                last_ar_addr     = bus.mem_araddr;
                                mphase           = 1;
                                cnt              = 0;
                            end else begin
                                cnt++;
                            end
                        end
                    end
                    1: begin
                        bus.mem_ar_ready = 1'b0;
                        if (cnt >= r_delay) begin
                            bus.mem_r_valid = 1'b1;
                            bus.mem_rdata   = mem_fn(last_ar_addr);
                            mphase          = 2;
                        end else begin
                            cnt++;
                        end
                    end
                    default: begin
                        bus.mem_r_valid = 1'b0;
                        mphase          = 0;
                        cnt             = 0;
                    end
                endcase
            end
        end
    end

    task automatic expect_txn(input logic id, input logic [AW-1:0] addr);
        exp_t e;
        e.id   = id;
        e.data = mem_fn(addr);
        exp_q.push_back(e);
    endtask

    task automatic drop(input logic id);
        @(posedge clk); #1;
        if (id == REQ_IMMU) bus.immu_ren = 1'b0;
        else                bus.dmmu_ren = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk); rstn = 1'b0;
        @(negedge clk); #2 rstn = 1'b1;
    endtask

    // Issue one read, wait for its done, pop the scoreboard and compare.
    task automatic txn(input logic id, input logic [AW-1:0] addr, output int lat);
        bit            done;
        exp_t          e;
        logic [DW-1:0] rd;
        done = 1'b0;
        @(posedge clk); #1;
        if (id == REQ_IMMU) begin
            bus.immu_ren = 1'b1; bus.immu_address = addr;
        end else begin
            bus.dmmu_ren = 1'b1; bus.dmmu_address = addr;
        end
        lat = 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            done = (id == REQ_IMMU) ? (bus.immu_ren && !bus.immu_stall)
                                    : (bus.dmmu_ren && !bus.dmmu_stall);
            if (!done) lat++;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL txn_timeout id=%0d addr=%h got no done required done", id, addr);
        end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL txn_unexpected id=%0d got done required none", id);
        end else begin
            e  = exp_q.pop_front();
            rd = (id == REQ_IMMU) ? bus.immu_rdata : bus.dmmu_rdata;
            if (e.id !== id || rd !== e.data) begin
                n_fail++;
                $display("FAIL txn_result got id=%0d data=%h required id=%0d data=%h", id, rd, e.id, e.data);
            end
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({bus.mem_ar_valid, bus.mem_r_ready, bus.immu_stall, bus.dmmu_stall} !== 4'b0 ||
            bus.mem_araddr !== '0 || bus.immu_rdata !== '0 || bus.dmmu_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got arv=%b rr=%b addr=%h ird=%h drd=%h required all zero",
                     bus.mem_ar_valid, bus.mem_r_ready, bus.mem_araddr, bus.immu_rdata, bus.dmmu_rdata);
        end
    endtask

    task automatic test_single_immu();
        int lat;
        ar_delay = 0; r_delay = 0;
        expect_txn(REQ_IMMU, 64'h8000_1000);
        txn(REQ_IMMU, 64'h8000_1000, lat);
        n_checks++;
        if (lat !== 3) begin
            n_fail++; $display("FAIL single_latency got=%0d required=3", lat);
        end
        n_checks++;
        if (last_ar_addr !== 64'h8000_1000) begin
            n_fail++; $display("FAIL single_araddr got=%h required=%h", last_ar_addr, 64'h8000_1000);
        end
        n_checks++;
        if (bus.dmmu_stall !== 1'b0) begin
            n_fail++; $display("FAIL single_dmmu_stall got=%b required=0", bus.dmmu_stall);
        end
        drop(REQ_IMMU);
    endtask

    task automatic test_simultaneous();
        apply_reset();
        expect_txn(REQ_IMMU, 64'h0000_0000_0010_2000);
        expect_txn(REQ_DMMU, 64'hFFFF_FFC0_0000_3008);
        fork
            begin int l; txn(REQ_IMMU, 64'h0000_0000_0010_2000, l); drop(REQ_IMMU); end
            begin int l; txn(REQ_DMMU, 64'hFFFF_FFC0_0000_3008, l); drop(REQ_DMMU); end
        join
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] ai[3];
        logic [AW-1:0] ad[3];
        ai = '{64'h1000, 64'h1_2000_0008, 64'hABCD_0000_0000_0010};
        ad = '{64'h2000, 64'h2_3000_0018, 64'h7777_0000_0000_0FF8};
        for (int k = 0; k < 3; k++) begin
            expect_txn(REQ_IMMU, ai[k]);
            expect_txn(REQ_DMMU, ad[k]);
        end
        fork
            begin int l; for (int k = 0; k < 3; k++) txn(REQ_IMMU, ai[k], l); drop(REQ_IMMU); end
            begin int l; for (int k = 0; k < 3; k++) txn(REQ_DMMU, ad[k], l); drop(REQ_DMMU); end
        join
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_leftover got=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int extra;
        ar_delay = 4; r_delay = 5;
        expect_txn(REQ_IMMU, 64'h0000_0040_5555_AAA8);
        txn(REQ_IMMU, 64'h0000_0040_5555_AAA8, lat);
        n_checks++;
        if (lat !== 12) begin
            n_fail++; $display("FAIL bp_latency got=%0d required=12", lat);
        end
        drop(REQ_IMMU);
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.mem_ar_valid) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++; $display("FAIL bp_extra_txn got=%0d required=0", extra);
        end
        ar_delay = 0; r_delay = 0;
    endtask

    task automatic test_abort();
        logic [DW-1:0] old_d;
        bit            seen;
        old_d = bus.dmmu_rdata;
        r_delay = 3;
        expect_txn(REQ_IMMU, 64'h0000_0000_9000_0100);
        fork
            begin
                @(posedge clk); #1;
                bus.dmmu_ren = 1'b1; bus.dmmu_address = 64'h0000_0000_A000_0200;
                seen = 1'b0;
                for (int k = 0; k < 20 && !seen; k++) begin
                    @(negedge clk);
                    seen = bus.mem_r_ready;
                end
                bus.dmmu_ren = 1'b0;
                n_checks++;
                if (!seen) begin
                    n_fail++; $display("FAIL abort_no_data_phase got r_ready=0 required 1");
                end
            end
            begin
                int l;
                @(posedge clk);
                @(posedge clk);
                txn(REQ_IMMU, 64'h0000_0000_9000_0100, l);
                drop(REQ_IMMU);
            end
        join
        n_checks++;
        if (bus.dmmu_rdata !== old_d) begin
            n_fail++; $display("FAIL abort_rdata got=%h required=%h", bus.dmmu_rdata, old_d);
        end
        r_delay = 0;
    endtask

    task automatic test_reset_mid_data();
        bit seen;
        int lat;
        r_delay = 6;
        @(posedge clk); #1;
        bus.immu_ren = 1'b1; bus.immu_address = 64'h0000_0000_C000_0008;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = bus.mem_r_ready;
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL rst_no_data_phase got r_ready=0 required 1");
        end
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if ({bus.mem_ar_valid, bus.mem_r_ready} !== 2'b00 || bus.mem_araddr !== '0 ||
            bus.immu_rdata !== '0 || bus.dmmu_rdata !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs got arv=%b rr=%b addr=%h ird=%h drd=%h required all zero",
                     bus.mem_ar_valid, bus.mem_r_ready, bus.mem_araddr, bus.immu_rdata, bus.dmmu_rdata);
        end
        bus.immu_ren = 1'b0;
        @(negedge clk); #2 rstn = 1'b1;
        r_delay = 0;
        inject_stray = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (bus.immu_rdata !== '0 || bus.mem_r_ready !== 1'b0 || bus.mem_ar_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_stray got ird=%h rr=%b arv=%b required 0/0/0",
                     bus.immu_rdata, bus.mem_r_ready, bus.mem_ar_valid);
        end
        expect_txn(REQ_IMMU, 64'h0000_0000_C000_1010);
        txn(REQ_IMMU, 64'h0000_0000_C000_1010, lat);
        n_checks++;
        if (lat !== 3) begin
            n_fail++; $display("FAIL rst_recover_latency got=%0d required=3", lat);
        end
        drop(REQ_IMMU);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.immu_ren = 1'b0; bus.immu_address = '0;
        bus.dmmu_ren = 1'b0; bus.dmmu_address = '0;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #12;
        test_reset();
        @(negedge clk); #2 rstn = 1'b1;
        test_single_immu();
        test_simultaneous();
        test_back_to_back();
        test_backpressure();
        test_abort();
        test_reset_mid_data();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
